// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Sequencing controller for a 5-stage (IF/ID/EX/MEM/WB) pipelined CPU. It
// drives the pipeline-register enables, the bubble/flush strobes and the PC
// source select. It resolves RAW hazards and branch/jump redirects, drains
// the pipeline after HLT, and counts retired instructions.
//
// Build option:
//   PIPE_FORWARDING_EN - when defined, EX/MEM/WB->EX forwarding is assumed to
//                        exist, so only load-use (and EX writers feeding a
//                        register-indirect jump's rs) cause stalls. When
//                        undefined, any EX/MEM/WB writer matching a used
//                        source stalls the ID instruction.
//
// Parameters:
//   CNT_W      - width of the retired-instruction counter
//   DRAIN_CYC  - cycles needed to empty EX/MEM/WB once HLT is accepted in ID
//
// Ports:
//   i_clk, i_reset                 rising-edge clock, synchronous active-high reset
//   i_id_rs, i_id_rt               source register indices of the ID instruction
//   i_id_use_rs, i_id_use_rt       ID instruction reads that source
//   i_id_is_jump                   JMP/JAL in ID (immediate target)
//   i_id_is_jreg                   JPR/JRL in ID (target from rs)
//   i_id_halt                      HLT in ID
//   i_ex_reg_write, i_ex_mem_read, i_ex_dest    EX-stage write info
//   i_mem_reg_write, i_mem_dest                 MEM-stage write info
//   i_wb_reg_write, i_wb_dest                   WB-stage write info
//   i_ex_is_branch, i_ex_branch_taken           branch resolved in EX
//   i_wb_valid                     a real instruction retires this cycle
//   o_pc_write                     PC register enable
//   o_ifid_write                   IF/ID register enable
//   o_ifid_flush                   load NOP into IF/ID
//   o_idex_bubble                  load NOP into ID/EX
//   o_pc_src                       00 PC+1, 01 jump target, 10 branch target, 11 rs
//   o_halted                       pipeline drained after HLT (sticky until reset)
//   o_num_inst                     retired-instruction count (wraps)
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
  parameter int CNT_W     = 16,
  parameter int DRAIN_CYC = 3
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [1:0]       i_id_rs,
  input  logic [1:0]       i_id_rt,
  input  logic             i_id_use_rs,
  input  logic             i_id_use_rt,
  input  logic             i_id_is_jump,
  input  logic             i_id_is_jreg,
  input  logic             i_id_halt,
  input  logic             i_ex_reg_write,
  input  logic             i_ex_mem_read,
  input  logic [1:0]       i_ex_dest,
  input  logic             i_mem_reg_write,
  input  logic [1:0]       i_mem_dest,
  input  logic             i_wb_reg_write,
  input  logic [1:0]       i_wb_dest,
  input  logic             i_ex_is_branch,
  input  logic             i_ex_branch_taken,
  input  logic             i_wb_valid,
  output logic             o_pc_write,
  output logic             o_ifid_write,
  output logic             o_ifid_flush,
  output logic             o_idex_bubble,
  output logic [1:0]       o_pc_src,
  output logic             o_halted,
  output logic [CNT_W-1:0] o_num_inst
);

  localparam int DW = (DRAIN_CYC < 2) ? 1 : $clog2(DRAIN_CYC + 1);

  localparam logic [1:0] PC_SEQ  = 2'b00;
  localparam logic [1:0] PC_JMP  = 2'b01;
  localparam logic [1:0] PC_BR   = 2'b10;
  localparam logic [1:0] PC_JREG = 2'b11;

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_DRAIN  = 2'b01,
    ST_HALTED = 2'b10
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [DW-1:0]    r_drain_cnt;
  logic [DW-1:0]    w_drain_cnt_nxt;
  logic [CNT_W-1:0] r_num_inst;

  logic w_use_rs;
  logic w_hz_rs;
  logic w_hz_rt;
  logic w_stall;
  logic w_br_taken;

  // A writer stage hits a source when it writes and its destination matches.
  function automatic logic writer_hit(input logic we, input logic [1:0] dest,
                                      input logic [1:0] src);
    return we && (dest == src);
  endfunction

  // Register-indirect jumps always read rs, even if the decoder left use_rs low.
  assign w_use_rs   = i_id_use_rs | i_id_is_jreg;
  assign w_br_taken = i_ex_is_branch & i_ex_branch_taken;

`ifdef PIPE_FORWARDING_EN
  // Forwarding covers ALU results; only a load in EX is too late for EX.
  // A jreg reads rs in ID, before any forwarding path, so an EX ALU writer
  // also has to be waited out.
  assign w_hz_rs = w_use_rs &
                   (writer_hit(i_ex_mem_read, i_ex_dest, i_id_rs) |
                    (i_id_is_jreg & writer_hit(i_ex_reg_write, i_ex_dest, i_id_rs)));
  assign w_hz_rt = i_id_use_rt & writer_hit(i_ex_mem_read, i_ex_dest, i_id_rt);

  logic w_unused_fwd;
  assign w_unused_fwd = ^{i_mem_reg_write, i_mem_dest, i_wb_reg_write, i_wb_dest};
`else
  // No forwarding and no register-file bypass: every in-flight writer blocks.
  assign w_hz_rs = w_use_rs &
                   (writer_hit(i_ex_reg_write,  i_ex_dest,  i_id_rs) |
                    writer_hit(i_mem_reg_write, i_mem_dest, i_id_rs) |
                    writer_hit(i_wb_reg_write,  i_wb_dest,  i_id_rs));
  assign w_hz_rt = i_id_use_rt &
                   (writer_hit(i_ex_reg_write,  i_ex_dest,  i_id_rt) |
                    writer_hit(i_mem_reg_write, i_mem_dest, i_id_rt) |
                    writer_hit(i_wb_reg_write,  i_wb_dest,  i_id_rt));

  logic w_unused_nofwd;
  assign w_unused_nofwd = i_ex_mem_read;
`endif

  assign w_stall = w_hz_rs | w_hz_rt;

  // Halt FSM state, drain counter and retired-instruction counter.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= ST_RUN;
      r_drain_cnt <= {DW{1'b0}};
      r_num_inst  <= {CNT_W{1'b0}};
    end else begin
      r_state     <= w_state_nxt;
      r_drain_cnt <= w_drain_cnt_nxt;
      if (i_wb_valid) begin
        r_num_inst <= r_num_inst + CNT_W'(1);
      end else begin
        r_num_inst <= r_num_inst;
      end
    end
  end

  // Next-state logic and combinational pipeline strobes.
  always_comb begin
    w_state_nxt     = r_state;
    w_drain_cnt_nxt = r_drain_cnt;
    o_pc_write      = 1'b1;
    o_ifid_write    = 1'b1;
    o_ifid_flush    = 1'b0;
    o_idex_bubble   = 1'b0;
    o_pc_src        = PC_SEQ;

    if (i_reset) begin
      o_pc_write      = 1'b0;
      o_ifid_write    = 1'b0;
      o_ifid_flush    = 1'b1;
      o_idex_bubble   = 1'b1;
      w_state_nxt     = ST_RUN;
      w_drain_cnt_nxt = {DW{1'b0}};
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_br_taken) begin
            // The ID instruction is wrong-path, so a pending stall is moot.
            o_pc_src      = PC_BR;
            o_ifid_flush  = 1'b1;
            o_idex_bubble = 1'b1;
          end else if (w_stall) begin
            o_pc_write    = 1'b0;
            o_ifid_write  = 1'b0;
            o_idex_bubble = 1'b1;
          end else if (i_id_halt) begin
            // Freeze fetch and keep HLT itself out of EX while older work drains.
            o_pc_write      = 1'b0;
            o_ifid_write    = 1'b0;
            o_idex_bubble   = 1'b1;
            w_state_nxt     = ST_DRAIN;
            w_drain_cnt_nxt = DW'(DRAIN_CYC);
          end else if (i_id_is_jreg) begin
            o_pc_src     = PC_JREG;
            o_ifid_flush = 1'b1;
          end else if (i_id_is_jump) begin
            o_pc_src     = PC_JMP;
            o_ifid_flush = 1'b1;
          end else begin
            o_pc_src = PC_SEQ;
          end
        end
        ST_DRAIN: begin
          o_pc_write    = 1'b0;
          o_ifid_write  = 1'b0;
          o_idex_bubble = 1'b1;
          if (r_drain_cnt <= DW'(1)) begin
            w_state_nxt     = ST_HALTED;
            w_drain_cnt_nxt = {DW{1'b0}};
          end else begin
            w_drain_cnt_nxt = r_drain_cnt - DW'(1);
          end
        end
        ST_HALTED: begin
          o_pc_write    = 1'b0;
          o_ifid_write  = 1'b0;
          o_idex_bubble = 1'b1;
        end
        default: begin
          // Unreachable encoding: freeze and recover to RUN.
          o_pc_write      = 1'b0;
          o_ifid_write    = 1'b0;
          o_idex_bubble   = 1'b1;
          w_state_nxt     = ST_RUN;
          w_drain_cnt_nxt = {DW{1'b0}};
        end
      endcase
    end
  end

  assign o_halted   = (r_state == ST_HALTED);
  assign o_num_inst = r_num_inst;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// Directed self-checking bench for pipeline_hazard_ctrl. The counter is built
// narrow (CNT_W=4) so that the wrap case is reached in a few cycles.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
// -----------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

  localparam int CNT_W     = 4;
  localparam int DRAIN_CYC = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       id_rs, id_rt;
  logic             id_use_rs, id_use_rt, id_is_jump, id_is_jreg, id_halt;
  logic             ex_reg_write, ex_mem_read;
  logic [1:0]       ex_dest;
  logic             mem_reg_write;
  logic [1:0]       mem_dest;
  logic             wb_reg_write;
  logic [1:0]       wb_dest;
  logic             ex_is_branch, ex_branch_taken, wb_valid;
  logic             pc_write, ifid_write, ifid_flush, idex_bubble;
  logic [1:0]       pc_src;
  logic             halted;
  logic [CNT_W-1:0] num_inst;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.CNT_W(CNT_W), .DRAIN_CYC(DRAIN_CYC)) dut (
    .i_clk(clk), .i_reset(reset),
    .i_id_rs(id_rs), .i_id_rt(id_rt),
    .i_id_use_rs(id_use_rs), .i_id_use_rt(id_use_rt),
    .i_id_is_jump(id_is_jump), .i_id_is_jreg(id_is_jreg), .i_id_halt(id_halt),
    .i_ex_reg_write(ex_reg_write), .i_ex_mem_read(ex_mem_read), .i_ex_dest(ex_dest),
    .i_mem_reg_write(mem_reg_write), .i_mem_dest(mem_dest),
    .i_wb_reg_write(wb_reg_write), .i_wb_dest(wb_dest),
    .i_ex_is_branch(ex_is_branch), .i_ex_branch_taken(ex_branch_taken),
    .i_wb_valid(wb_valid),
    .o_pc_write(pc_write), .o_ifid_write(ifid_write), .o_ifid_flush(ifid_flush),
    .o_idex_bubble(idex_bubble), .o_pc_src(pc_src),
    .o_halted(halted), .o_num_inst(num_inst)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ctl(input string tag, input logic pw, input logic iw,
                         input logic fl, input logic bb, input logic [1:0] src);
    chk({tag, ".pc_write"},    32'(pc_write),    32'(pw));
    chk({tag, ".ifid_write"},  32'(ifid_write),  32'(iw));
    chk({tag, ".ifid_flush"},  32'(ifid_flush),  32'(fl));
    chk({tag, ".idex_bubble"}, 32'(idex_bubble), 32'(bb));
    chk({tag, ".pc_src"},      32'(pc_src),      32'(src));
  endtask

  task automatic idle();
    id_rs = 2'd0; id_rt = 2'd0; id_use_rs = 1'b0; id_use_rt = 1'b0;
    id_is_jump = 1'b0; id_is_jreg = 1'b0; id_halt = 1'b0;
    ex_reg_write = 1'b0; ex_mem_read = 1'b0; ex_dest = 2'd0;
    mem_reg_write = 1'b0; mem_dest = 2'd0;
    wb_reg_write = 1'b0; wb_dest = 2'd0;
    ex_is_branch = 1'b0; ex_branch_taken = 1'b0; wb_valid = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    idle();
    id_is_jump = 1'b1;
    @(negedge clk);
    #1;
    chk_ctl("reset", 1'b0, 1'b0, 1'b1, 1'b1, 2'b00);
    step();
    reset = 1'b0;
    idle();
    #1;
    chk("reset.halted", 32'(halted), 32'd0);
    chk("reset.num_inst", 32'(num_inst), 32'd0);
    chk_ctl("run_idle", 1'b1, 1'b1, 1'b0, 1'b0, 2'b00);

    // Load-use: LWD r1 in EX, ADD reading r1 in ID.
    id_rs = 2'd1; id_use_rs = 1'b1;
    ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_dest = 2'd1;
    #1 chk_ctl("lu_ex", 1'b0, 1'b0, 1'b0, 1'b1, 2'b00);
    step();
    idle(); id_rs = 2'd1; id_use_rs = 1'b1; mem_reg_write = 1'b1; mem_dest = 2'd1;
`ifdef PIPE_FORWARDING_EN
    #1 chk_ctl("lu_mem", 1'b1, 1'b1, 1'b0, 1'b0, 2'b00);
`else
    #1 chk_ctl("lu_mem", 1'b0, 1'b0, 1'b0, 1'b1, 2'b00);
`endif
    step();
    idle(); id_rs = 2'd1; id_use_rs = 1'b1; wb_reg_write = 1'b1; wb_dest = 2'd1;
`ifdef PIPE_FORWARDING_EN
    #1 chk_ctl("lu_wb", 1'b1, 1'b1, 1'b0, 1'b0, 2'b00);
`else
    #1 chk_ctl("lu_wb", 1'b0, 1'b0, 1'b0, 1'b1, 2'b00);
`endif
    step();
    idle(); id_rs = 2'd1; id_use_rs = 1'b1;
    #1 chk_ctl("lu_clear", 1'b1, 1'b1, 1'b0, 1'b0, 2'b00);

    // Non-matching destination and unused source never stall.
    idle(); id_rs = 2'd1; id_use_rs = 1'b1; ex_reg_write = 1'b1; ex_dest = 2'd2;
    #1 chk_ctl("no_match", 1'b1, 1'b1, 1'b0, 1'b0, 2'b00);
    idle(); id_rs = 2'd1; ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_dest = 2'd1;
    #1 chk_ctl("unused_src", 1'b1, 1'b1, 1'b0, 1'b0, 2'b00);

    // rt against WB writer, and rs against an EX ALU writer.
    idle(); id_rt = 2'd3; id_use_rt = 1'b1; wb_reg_write = 1'b1; wb_dest = 2'd3;
`ifdef PIPE_FORWARDING_EN
    #1 chk_ctl("rt_wb", 1'b1, 1'b1, 1'b0, 1'b0, 2'b00);
`else
    #1 chk_ctl("rt_wb", 1'b0, 1'b0, 1'b0, 1'b1, 2'b00);
`endif
    idle(); id_rs = 2'd1; id_use_rs = 1'b1; ex_reg_write = 1'b1; ex_dest = 2'd1;
`ifdef PIPE_FORWARDING_EN
    #1 chk_ctl("rs_ex_alu", 1'b1, 1'b1, 1'b0, 1'b0, 2'b00);
`else
    #1 chk_ctl("rs_ex_alu", 1'b0, 1'b0, 1'b0, 1'b1, 2'b00);
`endif

    // Taken branch overrides a load-use stall; not-taken leaves the stall.
    idle(); id_rs = 2'd1; id_use_rs = 1'b1;
    ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_dest = 2'd1;
    ex_is_branch = 1'b1; ex_branch_taken = 1'b1;
    #1 chk_ctl("br_taken_hz", 1'b1, 1'b1, 1'b1, 1'b1, 2'b10);
    ex_branch_taken = 1'b0;
    #1 chk_ctl("br_nottaken_hz", 1'b0, 1'b0, 1'b0, 1'b1, 2'b00);
    idle(); ex_is_branch = 1'b1; ex_branch_taken = 1'b1; id_is_jump = 1'b1;
    #1 chk_ctl("br_over_jump", 1'b1, 1'b1, 1'b1, 1'b1, 2'b10);

    // Jumps.
    idle(); id_is_jump = 1'b1;
    #1 chk_ctl("jump", 1'b1, 1'b1, 1'b1, 1'b0, 2'b01);
    idle(); id_is_jreg = 1'b1; id_use_rs = 1'b1; id_rs = 2'd2;
    #1 chk_ctl("jreg", 1'b1, 1'b1, 1'b1, 1'b0, 2'b11);
    id_is_jump = 1'b1;
    #1 chk_ctl("jreg_over_jump", 1'b1, 1'b1, 1'b1, 1'b0, 2'b11);
    idle(); id_is_jreg = 1'b1; id_use_rs = 1'b1; id_rs = 2'd2;
    ex_reg_write = 1'b1; ex_dest = 2'd2;
    #1 chk_ctl("jreg_hz", 1'b0, 1'b0, 1'b0, 1'b1, 2'b00);
    step();
    idle(); id_is_jreg = 1'b1; id_use_rs = 1'b1; id_rs = 2'd2;
    #1 chk_ctl("jreg_after", 1'b1, 1'b1, 1'b1, 1'b0, 2'b11);

    // HLT while stalled is held off; HLT behind a taken branch is discarded.
    idle(); id_halt = 1'b1; id_rs = 2'd1; id_use_rs = 1'b1;
    ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_dest = 2'd1;
    #1 chk_ctl("halt_stall", 1'b0, 1'b0, 1'b0, 1'b1, 2'b00);
    step();
    idle();
    #1 chk_ctl("halt_stall_run", 1'b1, 1'b1, 1'b0, 1'b0, 2'b00);
    id_halt = 1'b1; ex_is_branch = 1'b1; ex_branch_taken = 1'b1;
    #1 chk_ctl("halt_br", 1'b1, 1'b1, 1'b1, 1'b1, 2'b10);
    step();
    idle();
    #1 chk_ctl("halt_br_run", 1'b1, 1'b1, 1'b0, 1'b0, 2'b00);

    // HLT accepted: three drain cycles, then sticky HALTED.
    id_halt = 1'b1;
    #1 chk_ctl("halt_acc", 1'b0, 1'b0, 1'b0, 1'b1, 2'b00);
    step();
    idle(); id_is_jump = 1'b1;
    #1 chk_ctl("drain1", 1'b0, 1'b0, 1'b0, 1'b1, 2'b00);
    chk("drain1.halted", 32'(halted), 32'd0);
    step();
    #1 chk("drain2.halted", 32'(halted), 32'd0);
    step();
    #1 chk("drain3.halted", 32'(halted), 32'd0);
    chk_ctl("drain3", 1'b0, 1'b0, 1'b0, 1'b1, 2'b00);
    step();
    #1 chk("halted_edge3", 32'(halted), 32'd1);
    chk_ctl("halted", 1'b0, 1'b0, 1'b0, 1'b1, 2'b00);
    wb_valid = 1'b1;
    step();
    wb_valid = 1'b0;
    #1 chk("halted.num_inst", 32'(num_inst), 32'd1);
    step();
    #1 chk("halted_sticky", 32'(halted), 32'd1);
    chk("halted_sticky.pc_write", 32'(pc_write), 32'd0);

    // Reset out of HALTED.
    reset = 1'b1;
    step();
    reset = 1'b0; idle();
    #1 chk("rst_halted.halted", 32'(halted), 32'd0);
    chk("rst_halted.num_inst", 32'(num_inst), 32'd0);
    chk_ctl("rst_halted", 1'b1, 1'b1, 1'b0, 1'b0, 2'b00);

    // Reset in DRAIN.
    id_halt = 1'b1; wb_valid = 1'b1;
    step();
    idle();
    #1 chk("drain_pre.num_inst", 32'(num_inst), 32'd1);
    chk_ctl("drain_pre", 1'b0, 1'b0, 1'b0, 1'b1, 2'b00);
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1 chk("rst_drain.halted", 32'(halted), 32'd0);
    chk("rst_drain.num_inst", 32'(num_inst), 32'd0);
    chk_ctl("rst_drain", 1'b1, 1'b1, 1'b0, 1'b0, 2'b00);
    step(); step(); step();
    #1 chk("rst_drain_later.halted", 32'(halted), 32'd0);
    chk("rst_drain_later.pc_write", 32'(pc_write), 32'd1);

    // Counter wrap with CNT_W=4: 15 -> 0 -> 1 after 17 pulses.
    wb_valid = 1'b1;
    for (int i = 0; i < 15; i++) step();
    wb_valid = 1'b0;
    #1 chk("cnt15", 32'(num_inst), 32'd15);
    wb_valid = 1'b1;
    step();
    wb_valid = 1'b0;
    #1 chk("cnt_wrap", 32'(num_inst), 32'd0);
    wb_valid = 1'b1;
    step();
    wb_valid = 1'b0;
    #1 chk("cnt17", 32'(num_inst), 32'd1);
    step();
    #1 chk("cnt_hold", 32'(num_inst), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
